// File: rtl/nn_pkg.sv
// Shared definitions for the nn pixel-loading stages: default frame geometry
// and the output FSM state encoding.
package nn_pkg;

    // Output word width: two pixel bytes per word.
    localparam int NN_DATA_WIDTH = 16;

    // Words per frame: one 28x28 image.
    localparam int NN_FRAME_LEN = 784;

    // Default word buffer depth (power of two).
    localparam int NN_FIFO_DEPTH = 16;

    // Output FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Assemble a word from its two bytes; the low byte arrives first.
    function automatic logic [15:0] nn_pack_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/nn_sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Writes while full and reads while empty are ignored.
module nn_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Storage array: written only on a legal write, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer update and registered read data (one cycle read latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/nn_frame_loader.sv
// Frame loader: packs a byte stream (low byte first) into 16-bit words,
// buffers them, and streams exactly one frame of FRAME_LEN words downstream
// under a level-sensitive read enable.
//
// Handshake: a byte moves across the input only in a cycle where
// in_valid and in_ready are both high; in_ready depends on registered state
// only, never on in_valid. A byte offered while in_ready is low is dropped
// and latches the sticky overflow flag. Downstream, out_valid marks the one
// cycle a word is presented; there is no backpressure beyond ren.
module nn_frame_loader
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = NN_DATA_WIDTH,
    parameter int FRAME_LEN  = NN_FRAME_LEN,
    parameter int FIFO_DEPTH = NN_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    input  logic                  ren,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Byte assembler state.
    logic [7:0]            lo_reg;
    logic [7:0]            hi_reg;
    logic                  byte_phase;     // 0: next byte is low, 1: next byte is high
    logic                  word_pending;   // complete word waiting to be pushed

    // Frame bookkeeping.
    logic [CNT_W-1:0]      in_cnt;         // words pushed in this frame
    logic [CNT_W-1:0]      out_cnt;        // words popped in this frame
    logic                  in_frame_full;  // all words of the frame pushed

    // Output FSM.
    logic [1:0]            state;
    logic [1:0]            next_state;

    // FIFO interface.
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] push_word;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    // Control strobes.
    logic                  accept;
    logic                  push;
    logic                  push_blocked;
    logic                  last_word_pending;
    logic                  pop;
    logic                  frame_clear;

    // A pending word goes to the FIFO the cycle after its high byte, or
    // later if the FIFO is full. While the final word of the frame is still
    // pending, input stays closed so no byte of the next frame sneaks in
    // before in_frame_full rises.
    assign push              = word_pending & ~fifo_full;
    assign push_blocked      = word_pending & fifo_full;
    assign last_word_pending = word_pending & (in_cnt == LAST_IDX);
    assign in_ready          = ~fifo_full & ~in_frame_full & ~push_blocked & ~last_word_pending;
    assign accept            = in_valid & in_ready;
    assign push_word         = DATA_WIDTH'(nn_pack_word(hi_reg, lo_reg));

    // Pop only while streaming; the cycle that shows out_last closes the
    // frame, so nothing is popped then.
    assign pop         = (state == ST_STREAM) & ren & ~fifo_empty & ~out_last;
    assign frame_clear = (state == ST_DONE) & ~ren;
    assign frame_done  = (state == ST_DONE);
    assign out_data    = fifo_rd_data;

    nn_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (push_word),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Byte assembler: low byte then high byte; a half word survives idle gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_reg       <= '0;
            hi_reg       <= '0;
            byte_phase   <= 1'b0;
            word_pending <= 1'b0;
        end else begin
            if (push) begin
                word_pending <= 1'b0;
            end
            if (accept) begin
                if (!byte_phase) begin
                    lo_reg <= in_byte;
                end else begin
                    hi_reg       <= in_byte;
                    word_pending <= 1'b1;
                end
                byte_phase <= ~byte_phase;
            end
        end
    end

    // Input word counter and frame-full flag; cleared when the frame is retired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt        <= '0;
            in_frame_full <= 1'b0;
        end else if (frame_clear) begin
            in_cnt        <= '0;
            in_frame_full <= 1'b0;
        end else if (push) begin
            if (in_cnt == LAST_IDX) begin
                in_cnt        <= '0;
                in_frame_full <= 1'b1;
            end else begin
                in_cnt <= in_cnt + CNT_ONE;
            end
        end
    end

    // Sticky overflow: any byte offered while input is closed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    // Output word counter; holds whenever no pop happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (frame_clear) begin
            out_cnt <= '0;
        end else if (pop) begin
            out_cnt <= (out_cnt == LAST_IDX) ? '0 : out_cnt + CNT_ONE;
        end
    end

    // Output strobes aligned with the FIFO's registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= pop;
            out_last  <= pop & (out_cnt == LAST_IDX);
        end
    end

    // Output FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (ren)      next_state = ST_STREAM;
            ST_STREAM: if (out_last) next_state = ST_DONE;
            ST_DONE:   if (!ren)     next_state = ST_IDLE;
            default:                 next_state = ST_IDLE;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Self-checking bench for nn_frame_loader: a table of single-word vectors,
// then multi-cycle frame sequences (full frame, mid-stream stall with
// overflow, reset mid-frame, back-to-back frames, toggled read enable).
module tb_nn_frame_loader;

    localparam int FRAME_LEN  = 784;
    localparam int FRAME_B    = 2 * FRAME_LEN;
    localparam int FIFO_DEPTH = 16;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        ren;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_done;
    logic        overflow;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_q[$];
    int          rx_idx = 0;
    int          rx_total = 0;
    int          last_total = 0;
    int          bytes_sent = 0;
    bit          abort = 1'b0;
    bit          junk_req = 1'b0;
    vec_t        vecs[5];

    always #5 clk = ~clk;

    nn_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .ren        (ren),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout expected=event", name);
    endtask

    // Scoreboard: every presented word is matched against the expected queue.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_idx = 0;
            end else begin
                if (out_valid) begin
                    rx_total++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: actual=%0h expected=none", out_data);
                    end else begin
                        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                    end
                    check("out_last", 32'(out_last), 32'(rx_idx == FRAME_LEN - 1));
                    if (out_last) last_total++;
                    rx_idx++;
                end
                if (frame_done) rx_idx = 0;
            end
        end
    endtask

    // Offer one byte only when in_ready is high; may inject one junk byte
    // while input is closed if requested.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && !abort) begin
            in_valid = junk_req;
            in_byte  = 8'hEE;
            junk_req = 1'b0;
            guard++;
            if (guard > 3000) begin
                fail_timeout("in_ready_wait");
                abort = 1'b1;
            end
            @(negedge clk);
        end
        if (abort) begin
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_byte  = b;
        end
    endtask

    // Queue the model's words for a frame of byte k = k & 0xFF, then send it.
    task automatic send_frame();
        for (int i = 0; i < FRAME_LEN; i++) begin
            exp_q.push_back({8'((2 * i + 1) & 255), 8'((2 * i) & 255)});
        end
        bytes_sent = 0;
        for (int k = 0; k < FRAME_B; k++) begin
            if (abort) break;
            send_byte(8'(k & 255));
            if (!abort) bytes_sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (!frame_done && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (!frame_done) fail_timeout("frame_done_wait");
    endtask

    task automatic check_frame(input string tag, input int w0, input int l0);
        check({tag, "_words"}, 32'(rx_total - w0), 32'(FRAME_LEN));
        check({tag, "_lasts"}, 32'(last_total - l0), 32'd1);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd1);
        check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_in_ready_closed"}, 32'(in_ready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        ren = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int l0;
        int g;

        vecs[0] = '{8'h34, 8'h12, 16'h1234};
        vecs[1] = '{8'hFF, 8'h00, 16'h00FF};
        vecs[2] = '{8'h00, 8'hFF, 16'hFF00};
        vecs[3] = '{8'hA5, 8'h5A, 16'h5AA5};
        vecs[4] = '{8'h01, 8'h80, 16'h8001};

        rst = 1'b1;
        in_valid = 1'b0;
        in_byte = 8'h00;
        ren = 1'b0;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single-word vectors: assemble with ren low, then release one word.
        for (int v = 0; v < 5; v++) begin
            exp_q.push_back(vecs[v].word);
            w0 = rx_total;
            send_byte(vecs[v].lo);
            send_byte(vecs[v].hi);
            @(negedge clk);
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            check("vec_no_output_ren_low", 32'(out_valid), 32'd0);
            ren = 1'b1;
            repeat (3) @(negedge clk);
            ren = 1'b0;
            repeat (2) @(negedge clk);
            check("vec_word_count", 32'(rx_total - w0), 32'd1);
        end

        // Full frame with ren held high.
        do_reset();
        ren = 1'b1;
        w0 = rx_total;
        l0 = last_total;
        send_frame();
        wait_done();
        check_frame("full", w0, l0);

        // Stall mid-stream: buffer fills, input closes, extra byte overflows.
        do_reset();
        ren = 1'b1;
        w0 = rx_total;
        l0 = last_total;
        fork
            send_frame();
            begin
                g = 0;
                while (rx_idx < 100 && g < 5000) begin
                    @(negedge clk);
                    g++;
                end
                if (rx_idx < 100) fail_timeout("stall_start_wait");
                ren = 1'b0;
                repeat (40) @(negedge clk);
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_buffered", 32'(bytes_sent / 2 - rx_idx), 32'(FIFO_DEPTH));
                check("stall_overflow_pre", 32'(overflow), 32'd0);
                junk_req = 1'b1;
                repeat (3) @(negedge clk);
                check("stall_overflow_set", 32'(overflow), 32'd1);
                ren = 1'b1;
            end
        join
        wait_done();
        check_frame("stall", w0, l0);
        check("stall_overflow_held", 32'(overflow), 32'd1);

        // Reset after word 300, then a clean frame from word 0.
        do_reset();
        ren = 1'b1;
        fork
            send_frame();
            begin
                g = 0;
                while (rx_idx < 301 && g < 5000) begin
                    @(negedge clk);
                    g++;
                end
                if (rx_idx < 301) fail_timeout("word300_wait");
                rst = 1'b1;
                abort = 1'b1;
                @(posedge clk);
                #1;
                check("midrst_out_valid", 32'(out_valid), 32'd0);
                check("midrst_out_data", 32'(out_data), 32'd0);
                check("midrst_out_last", 32'(out_last), 32'd0);
                check("midrst_frame_done", 32'(frame_done), 32'd0);
                check("midrst_overflow", 32'(overflow), 32'd0);
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
            end
        join
        abort = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        w0 = rx_total;
        l0 = last_total;
        send_frame();
        wait_done();
        check_frame("after_rst", w0, l0);

        // Retire the frame with a one-cycle ren drop, then a second frame.
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        check("retire_frame_done", 32'(frame_done), 32'd0);
        ren = 1'b1;
        w0 = rx_total;
        l0 = last_total;
        send_frame();
        wait_done();
        check_frame("second", w0, l0);

        // ren toggled every 3 cycles across a whole frame.
        @(negedge clk);
        ren = 1'b0;
        @(negedge clk);
        ren = 1'b1;
        w0 = rx_total;
        l0 = last_total;
        fork
            send_frame();
            begin
                int c = 0;
                while (c < 20000) begin
                    @(negedge clk);
                    if (frame_done) break;
                    c++;
                    if (c % 3 == 0) ren = ~ren;
                end
                ren = 1'b1;
            end
        join
        wait_done();
        check_frame("toggle", w0, l0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_frame_loader.md
NN_FRAME_LOADER -- requirements
Module: nn_frame_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: output word width; fixed at 16 (two bytes per word).
REQ-002 Parameter FRAME_LEN, default 784: words per frame (one 28x28 image).
REQ-003 Parameter FIFO_DEPTH, default 16: word buffer depth, power of two.
REQ-004 Port clk, input, 1: single clock; all logic on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port in_valid, input, 1: in_byte valid this cycle.
REQ-007 Port in_byte, input, 8: pixel byte stream, low byte first.
REQ-008 Port in_ready, output, 1: byte accepted when in_valid & in_ready.
REQ-009 Port ren, input, 1: downstream read enable; level-sensitive.
REQ-010 Port out_valid, output, 1: out_data valid this cycle.
REQ-011 Port out_data, output, DATA_WIDTH: assembled word {hi, lo}.
REQ-012 Port out_last, output, 1: high with the final word of a frame.
REQ-013 Port frame_done, output, 1: frame fully emitted, held until ren low.
REQ-014 Port overflow, output, 1: sticky error flag.

Function
REQ-015 Byte assembler: first accepted byte -> lo register; second -> hi; pushes {hi, lo} to the FIFO in the cycle after the second accept.
REQ-016 in_ready = ~fifo_full & ~in_frame_full & ~(hi byte pending & push blocked); FIFO never written when full.
REQ-017 Input word counter counts pushes 0..FRAME_LEN-1; at FRAME_LEN pushes in_frame_full sets and in_ready is low until the output FSM reaches IDLE from DONE.
REQ-018 in_valid while in_ready low: byte dropped, overflow set to 1 and held until reset.
REQ-019 Output FSM states: IDLE, STREAM, DONE.
REQ-020 IDLE -> STREAM when ren=1; no output in IDLE.
REQ-021 STREAM: each cycle with ren=1 and FIFO non-empty, pop one word; out_valid=1 with out_data registered (1-cycle pop-to-output latency).
REQ-022 STREAM with ren=0 or FIFO empty: out_valid=0, output counter holds; stream resumes with no word lost or duplicated.
REQ-023 Output counter 0..FRAME_LEN-1; word at count FRAME_LEN-1 drives out_last=1 for exactly that cycle; then STREAM -> DONE.
REQ-024 DONE: frame_done=1, out_valid=0; DONE -> IDLE when ren=0; on that transition clear both word counters and in_frame_full.
REQ-025 Push and pop in same cycle with FIFO full or empty: both succeed when legal (full: pop frees, push blocked this cycle; empty: pop blocked).
REQ-026 Odd byte at frame end never occurs by construction; lo-pending byte retained across idle gaps indefinitely.

Reset
REQ-027 rst asserted at any time, including mid-frame: FSM=IDLE, FIFO empty, counters=0, byte phase=lo, in_frame_full=0.
REQ-028 Outputs during/after reset: in_ready=1 (after release), out_valid=0, out_data=0, out_last=0, frame_done=0, overflow=0.

Structure
REQ-029 Shared package nn_pkg holds DATA_WIDTH, FRAME_LEN and the output FSM state encoding; all other nn stages import it.
REQ-030 One sub-module nn_sync_fifo (parameterised width/depth, registered read data, full/empty flags); assembler, counters and FSM live in nn_frame_loader.

Verification
REQ-031 Reset release, ren=0, bytes 0x34,0x12 -> FIFO holds 0x1234; out_valid stays 0.
REQ-032 Full frame: 1568 bytes value k&0xFF for byte k, ren=1 throughout -> 784 words, word i = {(2i+1)&0xFF, (2i)&0xFF}, out_last only on word 783, then frame_done=1.
REQ-033 ren=0 for 40 cycles mid-stream while bytes arrive -> in_ready falls after 16 words buffered; extra in_valid bytes set overflow=1; stream resumes in order.
REQ-034 ren toggled every 3 cycles over a full frame -> still exactly 784 words, no gaps in sequence, single out_last.
REQ-035 rst pulsed after word 300 -> all outputs reset next edge; following frame starts at word 0 with correct data.
REQ-036 After DONE, drop ren for 1 cycle, raise it, send second frame -> frame_done clears, second frame emitted identically to the first.
